id_ex_pipe_reg: RTL

ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

---
 rtl/id_ex_pipe_reg.sv | 136 +++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, flush and write-enable gating.
// Define ID_EX_SKID_EN for a two-entry skid buffer with a registered in_ready.
module id_ex_pipe_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned OP_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_op1,
   input  logic [DATA_W-1:0] in_op2,
   input  logic              in_we,
   input  logic [ADDR_W-1:0] in_waddr,
   input  logic [OP_W-1:0]   in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_op1,
   output logic [DATA_W-1:0] out_op2,
   output logic              out_we,
   output logic [ADDR_W-1:0] out_waddr,
   output logic [OP_W-1:0]   out_op,
   output logic [1:0]        count
);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] waddr;
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
   } entry_t;

   entry_t     in_ent;
   entry_t     head_q, head_d;
   logic [1:0] count_q, count_d;
   logic       accept, pop;

   always_comb begin
      in_ent.we    = in_we;
      in_ent.waddr = in_waddr;
      in_ent.op    = in_op;
      in_ent.op1   = in_op1;
      in_ent.op2   = in_op2;
   end

   assign out_valid = (count_q != 2'd0);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

`ifdef ID_EX_SKID_EN
   entry_t skid_q, skid_d;
   logic   rdy_q, rdy_d;

   // Registered ready; rst only masks it so nothing is credited during reset.
   assign in_ready = rdy_q & ~rst;

   always_comb begin
      head_d  = head_q;
      skid_d  = skid_q;
      count_d = count_q;
      if (rst || flush) begin
         head_d  = '0;
         skid_d  = '0;
         count_d = 2'd0;
      end else begin
         case ({accept, pop})
            2'b11: begin
               if (count_q == 2'd2) begin
                  head_d = skid_q;
                  skid_d = in_ent;
               end else begin
                  head_d = in_ent;
               end
            end
            2'b10: begin
               if (count_q == 2'd0) head_d = in_ent;
               else                 skid_d = in_ent;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               head_d  = skid_q;
               skid_d  = '0;
               count_d = count_q - 2'd1;
            end
            default: ;
         endcase
      end
      rdy_d = (count_d != 2'd2);
   end

   always_ff @(posedge clk) begin
      skid_q <= skid_d;
      rdy_q  <= rdy_d;
   end
`else
   assign in_ready = ~rst & (~out_valid | out_ready);

   always_comb begin
      head_d  = head_q;
      count_d = count_q;
      if (rst || flush) begin
         head_d  = '0;
         count_d = 2'd0;
      end else begin
         case ({accept, pop})
            2'b11, 2'b10: begin
               head_d  = in_ent;
               count_d = 2'd1;
            end
            2'b01: begin
               head_d  = '0;
               count_d = 2'd0;
            end
            default: ;
         endcase
      end
   end
`endif

   always_ff @(posedge clk) begin
      head_q  <= head_d;
      count_q <= count_d;
   end

   // Payload is forced to zero whenever nothing is presented.
   assign out_op1   = out_valid ? head_q.op1   : '0;
   assign out_op2   = out_valid ? head_q.op2   : '0;
   assign out_waddr = out_valid ? head_q.waddr : '0;
   assign out_op    = out_valid ? head_q.op    : '0;
   assign out_we    = out_valid & head_q.we;
   assign count     = count_q;

endmodule
